// File: rtl/pll_clk_mgr_if.sv
// Divider-configuration handshake between a controller and pll_clk_mgr.
// The master drives requests; the clock manager acknowledges and flags bad channel indices.
interface pll_clk_mgr_if #(
    parameter int CNT_W = 8
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [2:0]       cfg_ch;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_err;

    modport master (output cfg_valid, cfg_ch, cfg_div, input cfg_ready, cfg_err);
    modport slave  (input cfg_valid, cfg_ch, cfg_div, output cfg_ready, cfg_err);
endinterface

// File: rtl/pll_clk_mgr.sv
// PLL reset/lock sequencer with per-channel programmable clock-enable dividers.
// Downstream logic is released only while a filtered lock is held.
module pll_clk_mgr #(
    parameter int NUM_CH    = 4,
    parameter int CNT_W     = 8,
    parameter int DIV_INIT  = 1,
    parameter int RST_HOLD  = 16,
    parameter int LOCK_FILT = 64,
    parameter int LOCK_TMO  = 4096
) (
    input  logic              clkin,
    input  logic              rst_n,
    input  logic              pll_lock,
    output logic              pll_reset,
    pll_clk_mgr_if.slave      cfg,
    output logic [NUM_CH-1:0] ce,
    output logic              sys_rst_n,
    output logic              locked,
    output logic [7:0]        relock_cnt
);

    localparam int HOLD_W = $clog2(RST_HOLD + 1);
    localparam int FILT_W = $clog2(LOCK_FILT + 1);
    localparam int TMO_W  = $clog2(LOCK_TMO + 1);

    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        RUN       = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                sync1_q, lock_s_q;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [FILT_W-1:0]   filt_q, filt_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [7:0]          relock_q, relock_d;
    logic                pll_reset_q, sys_rst_q, locked_q;
    logic                rdy_q, err_q, err_d;

    logic [CNT_W-1:0]    div_q [NUM_CH];
    logic [CNT_W-1:0]    div_d [NUM_CH];
    logic [CNT_W-1:0]    cnt_q [NUM_CH];
    logic [CNT_W-1:0]    cnt_d [NUM_CH];
    logic [NUM_CH-1:0]   ce_q, ce_d;

    logic                cfg_acc, cfg_ok, run_stay;

    function automatic logic [CNT_W-1:0] last_cnt(input logic [CNT_W-1:0] d);
        return (d == '0) ? '0 : d - CNT_W'(1);
    endfunction

    always_comb begin
        state_d  = state_q;
        hold_d   = '0;
        filt_d   = '0;
        tmo_d    = '0;
        relock_d = relock_q;
        unique case (state_q)
            PLL_RST: begin
                if (hold_q == HOLD_W'(RST_HOLD - 1)) begin
                    state_d = WAIT_LOCK;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            WAIT_LOCK: begin
                filt_d = lock_s_q ? filt_q + FILT_W'(1) : '0;
                tmo_d  = tmo_q + TMO_W'(1);
                // A completed filter wins over a simultaneous timeout.
                if (filt_q == FILT_W'(LOCK_FILT)) begin
                    state_d = RUN;
                    filt_d  = '0;
                    tmo_d   = '0;
                end else if (tmo_q == TMO_W'(LOCK_TMO - 1)) begin
                    state_d = PLL_RST;
                    filt_d  = '0;
                    tmo_d   = '0;
                end
            end
            RUN: begin
                if (!lock_s_q) begin
                    state_d = PLL_RST;
                    if (relock_q != 8'hFF) relock_d = relock_q + 8'd1;
                end
            end
            default: state_d = PLL_RST;
        endcase
    end

    assign cfg_acc  = cfg.cfg_valid & rdy_q;
    assign cfg_ok   = cfg_acc && ({29'd0, cfg.cfg_ch} < 32'(NUM_CH));
    assign err_d    = cfg_acc && !cfg_ok;
    // Counting only while RUN persists keeps ce and counters at 0 on the exit edge.
    assign run_stay = (state_q == RUN) && (state_d == RUN);

    always_comb begin
        ce_d = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            div_d[i] = div_q[i];
            cnt_d[i] = '0;
            if (run_stay) begin
                if (cnt_q[i] == last_cnt(div_q[i])) begin
                    ce_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
            if (cfg_ok && (cfg.cfg_ch == 3'(i))) begin
                div_d[i] = cfg.cfg_div;
                cnt_d[i] = '0;
                ce_d[i]  = 1'b0;
            end
        end
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b0;
            lock_s_q    <= 1'b0;
            state_q     <= PLL_RST;
            hold_q      <= '0;
            filt_q      <= '0;
            tmo_q       <= '0;
            relock_q    <= '0;
            pll_reset_q <= 1'b1;
            sys_rst_q   <= 1'b0;
            locked_q    <= 1'b0;
            rdy_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            sync1_q     <= pll_lock;
            lock_s_q    <= sync1_q;
            state_q     <= state_d;
            hold_q      <= hold_d;
            filt_q      <= filt_d;
            tmo_q       <= tmo_d;
            relock_q    <= relock_d;
            pll_reset_q <= (state_d == PLL_RST);
            sys_rst_q   <= (state_d == RUN);
            locked_q    <= (state_d == RUN);
            rdy_q       <= 1'b1;
            err_q       <= err_d;
        end
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            ce_q <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                div_q[i] <= CNT_W'(DIV_INIT);
                cnt_q[i] <= '0;
            end
        end else begin
            ce_q <= ce_d;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                div_q[i] <= div_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign pll_reset     = pll_reset_q;
    assign sys_rst_n     = sys_rst_q;
    assign locked        = locked_q;
    assign relock_cnt    = relock_q;
    assign ce            = ce_q;
    assign cfg.cfg_ready = rdy_q;
    assign cfg.cfg_err   = err_q;

endmodule

// File: tb/tb_pll_clk_mgr.sv
// Scenario bench for pll_clk_mgr: lock sequencing, timeouts, divider programming and relock.
// Expected clock-enable patterns are queued when stimulus is applied and popped per cycle.
module tb_pll_clk_mgr;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;

    logic              clkin = 1'b0;
    logic              rst_n;
    logic              pll_lock;
    logic              pll_reset;
    logic [NUM_CH-1:0] ce;
    logic              sys_rst_n;
    logic              locked;
    logic [7:0]        relock_cnt;

    pll_clk_mgr_if #(.CNT_W(CNT_W)) cfg_bus ();

    pll_clk_mgr #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DIV_INIT(1),
        .RST_HOLD(16), .LOCK_FILT(64), .LOCK_TMO(4096)
    ) dut (
        .clkin(clkin), .rst_n(rst_n), .pll_lock(pll_lock), .pll_reset(pll_reset),
        .cfg(cfg_bus), .ce(ce), .sys_rst_n(sys_rst_n), .locked(locked),
        .relock_cnt(relock_cnt)
    );

    always #5 clkin = ~clkin;

    int cyc = 0;
    always @(posedge clkin) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    int m_div [NUM_CH] = '{1, 1, 1, 1};
    int m_org [NUM_CH] = '{0, 0, 0, 0};
    logic [NUM_CH-1:0] sb_q [$];

    // Channel pattern after its phase origin: pulse when t is a positive multiple of max(div,1).
    function automatic logic [NUM_CH-1:0] model_ce(input int c);
        logic [NUM_CH-1:0] v;
        v = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            int eff, t;
            eff = (m_div[ch] == 0) ? 1 : m_div[ch];
            t   = c - m_org[ch];
            v[ch] = (t >= 1) && ((t % eff) == 0);
        end
        return v;
    endfunction

    task automatic step();
        @(posedge clkin);
        #1;
    endtask

    task automatic sb_fill(input int n);
        for (int k = 1; k <= n; k++) sb_q.push_back(model_ce(cyc + k));
    endtask

    task automatic set_origin_all(input int e);
        for (int ch = 0; ch < NUM_CH; ch++) m_org[ch] = e;
    endtask

    task automatic wait_locked(input int limit, output int edge_at, output bit seen);
        seen = 1'b0;
        edge_at = -1;
        for (int k = 0; k < limit && !seen; k++) begin
            step();
            if (locked === 1'b1) begin
                seen = 1'b1;
                edge_at = cyc;
            end
        end
    endtask

    task automatic wait_sysrst_low(input int limit, output int k_at);
        k_at = -1;
        for (int k = 1; k <= limit && k_at < 0; k++) begin
            step();
            if (sys_rst_n === 1'b0) k_at = k;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pll_lock = 1'b0;
        cfg_bus.cfg_valid = 1'b0;
        cfg_bus.cfg_ch = '0;
        cfg_bus.cfg_div = '0;
        repeat (3) step();
        checks++; if (pll_reset !== 1'b1) begin failures++; $display("FAIL rst_pll_reset got=%b exp=1", pll_reset); end
        checks++; if (sys_rst_n !== 1'b0) begin failures++; $display("FAIL rst_sys_rst_n got=%b exp=0", sys_rst_n); end
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL rst_locked got=%b exp=0", locked); end
        checks++; if (ce !== '0) begin failures++; $display("FAIL rst_ce got=%b exp=0000", ce); end
        checks++; if (cfg_bus.cfg_ready !== 1'b0) begin failures++; $display("FAIL rst_cfg_ready got=%b exp=0", cfg_bus.cfg_ready); end
        checks++; if (cfg_bus.cfg_err !== 1'b0) begin failures++; $display("FAIL rst_cfg_err got=%b exp=0", cfg_bus.cfg_err); end
        checks++; if (relock_cnt !== 8'd0) begin failures++; $display("FAIL rst_relock_cnt got=%0d exp=0", relock_cnt); end
    endtask

    // Lock never arrives: 16 reset cycles, 4096 waiting cycles, repeat.
    task automatic test_timeout();
        int fall [$];
        int rise [$];
        logic prev;
        bit lock_seen;
        bit rdy_bad;
        lock_seen = 1'b0;
        rdy_bad = 1'b0;
        prev = pll_reset;
        rst_n = 1'b1;
        for (int k = 1; k <= 8230; k++) begin
            step();
            if (prev && !pll_reset) fall.push_back(k);
            if (!prev && pll_reset) rise.push_back(k);
            prev = pll_reset;
            if (locked !== 1'b0 || sys_rst_n !== 1'b0) lock_seen = 1'b1;
            if (cfg_bus.cfg_ready !== 1'b1) rdy_bad = 1'b1;
        end
        checks++;
        if (fall.size() != 2 || fall[0] != 16 || fall[1] != 4128) begin
            failures++;
            $display("FAIL tmo_pll_reset_fall got_n=%0d first=%0d second=%0d exp=16,4128",
                     fall.size(), (fall.size() > 0) ? fall[0] : -1, (fall.size() > 1) ? fall[1] : -1);
        end
        checks++;
        if (rise.size() != 2 || rise[0] != 4112 || rise[1] != 8224) begin
            failures++;
            $display("FAIL tmo_pll_reset_rise got_n=%0d first=%0d second=%0d exp=4112,8224",
                     rise.size(), (rise.size() > 0) ? rise[0] : -1, (rise.size() > 1) ? rise[1] : -1);
        end
        checks++; if (lock_seen) begin failures++; $display("FAIL tmo_locked got=1 exp=0 throughout"); end
        checks++; if (rdy_bad) begin failures++; $display("FAIL tmo_cfg_ready got=0 exp=1 throughout"); end
    endtask

    // Lock already stable: synchroniser settles inside the hold, so RUN at 16+64+1.
    task automatic test_lock_acquire();
        int t0, k_low, k_lock;
        bit mism;
        logic [NUM_CH-1:0] exp_v;
        rst_n = 1'b0;
        pll_lock = 1'b1;
        repeat (2) step();
        rst_n = 1'b1;
        t0 = cyc;
        k_low = -1;
        k_lock = -1;
        mism = 1'b0;
        for (int k = 1; k <= 120 && k_lock < 0; k++) begin
            step();
            if (k_low < 0 && pll_reset === 1'b0) k_low = k;
            if (locked === 1'b1) k_lock = k;
            if (sys_rst_n !== locked) mism = 1'b1;
        end
        checks++; if (k_low != 16) begin failures++; $display("FAIL acq_pll_reset_len got=%0d exp=16", k_low); end
        checks++; if (k_lock != 81) begin failures++; $display("FAIL acq_locked_edge got=%0d exp=81", k_lock); end
        checks++; if (mism) begin failures++; $display("FAIL acq_sys_rst_n_vs_locked got=differ exp=equal"); end
        checks++; if (ce !== '0) begin failures++; $display("FAIL acq_ce_entry got=%b exp=0000", ce); end
        set_origin_all(t0 + 81);
        sb_fill(12);
        while (sb_q.size() > 0) begin
            step();
            exp_v = sb_q.pop_front();
            checks++; if (ce !== exp_v) begin failures++; $display("FAIL acq_ce@%0d got=%b exp=%b", cyc, ce, exp_v); end
        end
    endtask

    // Back-to-back writes: ch1 divide-by-5, ch2 divide value 0.
    task automatic test_cfg();
        int c;
        logic [NUM_CH-1:0] exp_v;
        c = cyc;
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_ch = 3'd1;
        cfg_bus.cfg_div = 8'd5;
        step();
        cfg_bus.cfg_ch = 3'd2;
        cfg_bus.cfg_div = 8'd0;
        step();
        cfg_bus.cfg_valid = 1'b0;
        checks++; if (cfg_bus.cfg_err !== 1'b0) begin failures++; $display("FAIL cfg_err_valid got=%b exp=0", cfg_bus.cfg_err); end
        m_div[1] = 5; m_org[1] = c + 1;
        m_div[2] = 0; m_org[2] = c + 2;
        sb_fill(30);
        while (sb_q.size() > 0) begin
            step();
            exp_v = sb_q.pop_front();
            checks++; if (ce !== exp_v) begin failures++; $display("FAIL cfg_ce@%0d got=%b exp=%b", cyc, ce, exp_v); end
        end
    endtask

    task automatic test_cfg_err();
        logic [NUM_CH-1:0] exp_v;
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_ch = 3'd7;
        cfg_bus.cfg_div = 8'd9;
        sb_fill(20);
        step();
        cfg_bus.cfg_valid = 1'b0;
        checks++; if (cfg_bus.cfg_err !== 1'b1) begin failures++; $display("FAIL err_pulse got=%b exp=1", cfg_bus.cfg_err); end
        exp_v = sb_q.pop_front();
        checks++; if (ce !== exp_v) begin failures++; $display("FAIL err_ce@%0d got=%b exp=%b", cyc, ce, exp_v); end
        step();
        checks++; if (cfg_bus.cfg_err !== 1'b0) begin failures++; $display("FAIL err_pulse_end got=%b exp=0", cfg_bus.cfg_err); end
        exp_v = sb_q.pop_front();
        checks++; if (ce !== exp_v) begin failures++; $display("FAIL err_ce@%0d got=%b exp=%b", cyc, ce, exp_v); end
        while (sb_q.size() > 0) begin
            step();
            exp_v = sb_q.pop_front();
            checks++; if (ce !== exp_v) begin failures++; $display("FAIL err_ce@%0d got=%b exp=%b", cyc, ce, exp_v); end
        end
    endtask

    // Loss of lock: two synchroniser stages plus the state edge.
    task automatic test_relock();
        int k_at, x, e;
        bit seen;
        logic [NUM_CH-1:0] exp_v;
        pll_lock = 1'b0;
        wait_sysrst_low(10, k_at);
        x = cyc;
        checks++; if (k_at != 3) begin failures++; $display("FAIL relock_drop_latency got=%0d exp=3", k_at); end
        checks++; if (ce !== '0) begin failures++; $display("FAIL relock_ce_off got=%b exp=0000", ce); end
        checks++; if (relock_cnt !== 8'd1) begin failures++; $display("FAIL relock_cnt1 got=%0d exp=1", relock_cnt); end
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL relock_locked_off got=%b exp=0", locked); end
        pll_lock = 1'b1;
        wait_locked(200, e, seen);
        checks++; if (!seen || e - x != 81) begin failures++; $display("FAIL relock_edge got=%0d exp=81", seen ? e - x : -1); end
        set_origin_all(e);
        sb_fill(25);
        while (sb_q.size() > 0) begin
            step();
            exp_v = sb_q.pop_front();
            checks++; if (ce !== exp_v) begin failures++; $display("FAIL relock_ce@%0d got=%b exp=%b", cyc, ce, exp_v); end
        end
    endtask

    // One-cycle dropout while the filter sits around 50 restarts the 64-cycle filter.
    task automatic test_lock_glitch();
        int k_at, x, e;
        bit seen;
        pll_lock = 1'b0;
        wait_sysrst_low(10, k_at);
        x = cyc;
        checks++; if (relock_cnt !== 8'd2) begin failures++; $display("FAIL glitch_cnt2 got=%0d exp=2", relock_cnt); end
        pll_lock = 1'b1;
        repeat (65) step();
        pll_lock = 1'b0;
        step();
        pll_lock = 1'b1;
        wait_locked(200, e, seen);
        checks++; if (!seen || e - x != 133) begin failures++; $display("FAIL glitch_edge got=%0d exp=133", seen ? e - x : -1); end
    endtask

    task automatic test_relock_saturate();
        int k_at, e;
        bit seen;
        bit bad;
        bad = 1'b0;
        for (int n = 3; n <= 300 && !bad; n++) begin
            pll_lock = 1'b0;
            wait_sysrst_low(10, k_at);
            if (k_at < 0) bad = 1'b1;
            if (n == 254) begin
                checks++; if (relock_cnt !== 8'd254) begin failures++; $display("FAIL sat_cnt254 got=%0d exp=254", relock_cnt); end
            end
            pll_lock = 1'b1;
            wait_locked(200, e, seen);
            if (!seen) bad = 1'b1;
        end
        checks++; if (bad) begin failures++; $display("FAIL sat_loop got=stalled exp=relock each pass"); end
        checks++; if (relock_cnt !== 8'd255) begin failures++; $display("FAIL sat_cnt255 got=%0d exp=255", relock_cnt); end
    endtask

    task automatic test_reset_mid_run();
        int t0, e;
        bit seen;
        logic [NUM_CH-1:0] exp_v;
        #3 rst_n = 1'b0;
        #1;
        checks++; if (pll_reset !== 1'b1 || sys_rst_n !== 1'b0 || locked !== 1'b0) begin
            failures++; $display("FAIL mid_rst_ctrl got=%b%b%b exp=100", pll_reset, sys_rst_n, locked); end
        checks++; if (ce !== '0 || cfg_bus.cfg_ready !== 1'b0 || relock_cnt !== 8'd0) begin
            failures++; $display("FAIL mid_rst_outs got=ce%b rdy%b cnt%0d exp=ce0000 rdy0 cnt0", ce, cfg_bus.cfg_ready, relock_cnt); end
        step();
        step();
        rst_n = 1'b1;
        t0 = cyc;
        wait_locked(200, e, seen);
        checks++; if (!seen || e - t0 != 81) begin failures++; $display("FAIL mid_rst_relock got=%0d exp=81", seen ? e - t0 : -1); end
        for (int ch = 0; ch < NUM_CH; ch++) m_div[ch] = 1;
        set_origin_all(e);
        sb_fill(12);
        while (sb_q.size() > 0) begin
            step();
            exp_v = sb_q.pop_front();
            checks++; if (ce !== exp_v) begin failures++; $display("FAIL mid_rst_ce@%0d got=%b exp=%b", cyc, ce, exp_v); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_timeout();
        test_lock_acquire();
        test_cfg();
        test_cfg_err();
        test_relock();
        test_lock_glitch();
        test_relock_saturate();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
